// File: rtl/int_issue_queue.sv
// ----------------------------------------------------------------------------
// int_issue_queue
//   Data-capture issue queue for one integer execution block. It accepts
//   renamed uops from dispatch and captures operand values from the writeback
//   bus. Each cycle it issues the oldest ready uop. On a redirect it squashes
//   every entry younger than the redirecting branch.
//
//   Optional feature macro: ISQ_WAKEUP_BYPASS_EN
//     defined   : a source woken by wb this cycle counts as ready in this
//                 cycle's select, and its value is taken straight from
//                 wb_result.
//     undefined : a wakeup becomes visible to select one cycle after wb.
//
//   Ports
//     clock, reset                      clock, synchronous active-high reset
//     enq_*        (in)  / enq_ready    dispatch uop and back-pressure
//     wb_valid/wb_prd/wb_result         writeback / wakeup bus
//     redirect_valid/_robidx_flag/_robidx   redirecting branch age
//     iss_*        (out)                issued uop (all zero when !iss_valid)
//     occupancy    (out)                number of valid entries
// ----------------------------------------------------------------------------

// One queue slot: holds the payload and captures wakeups for both sources.
module int_issue_queue_entry #(
  parameter int PREG_W = 6,
  parameter int ROB_W  = 6,
  parameter int CTRL_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we_i,     // load a new uop into this slot
  input  logic              clr_i,    // issued or squashed
  input  logic [PREG_W-1:0] enq_prd_i,
  input  logic [PREG_W-1:0] enq_prs1_i,
  input  logic [PREG_W-1:0] enq_prs2_i,
  input  logic              enq_src1_rdy_i,
  input  logic              enq_src2_rdy_i,
  input  logic [63:0]       enq_src1_i,
  input  logic [63:0]       enq_src2_i,
  input  logic [63:0]       enq_imm_i,
  input  logic [63:0]       enq_pc_i,
  input  logic              enq_flag_i,
  input  logic [ROB_W-1:0]  enq_rob_i,
  input  logic [CTRL_W-1:0] enq_ctrl_i,
  input  logic              wb_valid_i,
  input  logic [PREG_W-1:0] wb_prd_i,
  input  logic [63:0]       wb_result_i,
  output logic              vld_o,
  output logic              rdy_o,
  output logic [PREG_W-1:0] prd_o,
  output logic [63:0]       src1_o,
  output logic [63:0]       src2_o,
  output logic [63:0]       imm_o,
  output logic [63:0]       pc_o,
  output logic              flag_o,
  output logic [ROB_W-1:0]  rob_o,
  output logic [CTRL_W-1:0] ctrl_o
);
  logic              vld_q, vld_d;
  logic              s1rdy_q, s1rdy_d, s2rdy_q, s2rdy_d;
  logic [PREG_W-1:0] prs1_q, prs1_d, prs2_q, prs2_d, prd_q, prd_d;
  logic [63:0]       src1_q, src1_d, src2_q, src2_d, imm_q, imm_d, pc_q, pc_d;
  logic              flag_q, flag_d;
  logic [ROB_W-1:0]  rob_q, rob_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  logic wk1, wk2, ewk1, ewk2;

  // Wakeup of a resident pending source, and of an arriving pending source.
  assign wk1  = wb_valid_i & vld_q & ~s1rdy_q & (prs1_q == wb_prd_i);
  assign wk2  = wb_valid_i & vld_q & ~s2rdy_q & (prs2_q == wb_prd_i);
  assign ewk1 = wb_valid_i & ~enq_src1_rdy_i & (enq_prs1_i == wb_prd_i);
  assign ewk2 = wb_valid_i & ~enq_src2_rdy_i & (enq_prs2_i == wb_prd_i);

  always_comb begin
    vld_d   = vld_q;
    s1rdy_d = s1rdy_q;
    s2rdy_d = s2rdy_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    prs1_d  = prs1_q;
    prs2_d  = prs2_q;
    prd_d   = prd_q;
    imm_d   = imm_q;
    pc_d    = pc_q;
    flag_d  = flag_q;
    rob_d   = rob_q;
    ctrl_d  = ctrl_q;
    if (we_i) begin
      vld_d   = 1'b1;
      s1rdy_d = enq_src1_rdy_i | ewk1;
      s2rdy_d = enq_src2_rdy_i | ewk2;
      src1_d  = enq_src1_rdy_i ? enq_src1_i : wb_result_i;
      src2_d  = enq_src2_rdy_i ? enq_src2_i : wb_result_i;
      prs1_d  = enq_prs1_i;
      prs2_d  = enq_prs2_i;
      prd_d   = enq_prd_i;
      imm_d   = enq_imm_i;
      pc_d    = enq_pc_i;
      flag_d  = enq_flag_i;
      rob_d   = enq_rob_i;
      ctrl_d  = enq_ctrl_i;
    end else begin
      if (clr_i) vld_d = 1'b0;
      if (wk1) begin
        s1rdy_d = 1'b1;
        src1_d  = wb_result_i;
      end
      if (wk2) begin
        s2rdy_d = 1'b1;
        src2_d  = wb_result_i;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q   <= 1'b0;
      s1rdy_q <= 1'b0;
      s2rdy_q <= 1'b0;
      src1_q  <= '0;
      src2_q  <= '0;
      prs1_q  <= '0;
      prs2_q  <= '0;
      prd_q   <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      flag_q  <= 1'b0;
      rob_q   <= '0;
      ctrl_q  <= '0;
    end else begin
      vld_q   <= vld_d;
      s1rdy_q <= s1rdy_d;
      s2rdy_q <= s2rdy_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      prs1_q  <= prs1_d;
      prs2_q  <= prs2_d;
      prd_q   <= prd_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      flag_q  <= flag_d;
      rob_q   <= rob_d;
      ctrl_q  <= ctrl_d;
    end
  end

`ifdef ISQ_WAKEUP_BYPASS_EN
  // A source being woken right now is usable this cycle, value from the bus.
  assign rdy_o  = vld_q & (s1rdy_q | wk1) & (s2rdy_q | wk2);
  assign src1_o = s1rdy_q ? src1_q : wb_result_i;
  assign src2_o = s2rdy_q ? src2_q : wb_result_i;
`else
  assign rdy_o  = vld_q & s1rdy_q & s2rdy_q;
  assign src1_o = src1_q;
  assign src2_o = src2_q;
`endif

  assign vld_o  = vld_q;
  assign prd_o  = prd_q;
  assign imm_o  = imm_q;
  assign pc_o   = pc_q;
  assign flag_o = flag_q;
  assign rob_o  = rob_q;
  assign ctrl_o = ctrl_q;
endmodule

module int_issue_queue #(
  parameter int DEPTH  = 8,
  parameter int PREG_W = 6,
  parameter int ROB_W  = 6,
  parameter int CTRL_W = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [PREG_W-1:0]        enq_prd,
  input  logic [PREG_W-1:0]        enq_prs1,
  input  logic [PREG_W-1:0]        enq_prs2,
  input  logic                     enq_src1_rdy,
  input  logic                     enq_src2_rdy,
  input  logic [63:0]              enq_src1,
  input  logic [63:0]              enq_src2,
  input  logic [63:0]              enq_imm,
  input  logic [63:0]              enq_pc,
  input  logic                     enq_robidx_flag,
  input  logic [ROB_W-1:0]         enq_robidx,
  input  logic [CTRL_W-1:0]        enq_ctrl,
  input  logic                     wb_valid,
  input  logic [PREG_W-1:0]        wb_prd,
  input  logic [63:0]              wb_result,
  input  logic                     redirect_valid,
  input  logic                     redirect_robidx_flag,
  input  logic [ROB_W-1:0]         redirect_robidx,
  output logic                     iss_valid,
  output logic [PREG_W-1:0]        iss_prd,
  output logic [63:0]              iss_src1,
  output logic [63:0]              iss_src2,
  output logic [63:0]              iss_imm,
  output logic [63:0]              iss_pc,
  output logic                     iss_robidx_flag,
  output logic [ROB_W-1:0]         iss_robidx,
  output logic [CTRL_W-1:0]        iss_ctrl,
  output logic [$clog2(DEPTH):0]   occupancy
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Age compare on (wrap flag, index): a is older than b.
  function automatic logic older(input logic fa, input logic [ROB_W-1:0] ia,
                                 input logic fb, input logic [ROB_W-1:0] ib);
    return (fa == fb) ? (ia < ib) : (ia > ib);
  endfunction

  logic [DEPTH-1:0]             e_vld, e_rdy, e_flag, e_we, e_clr;
  logic [DEPTH-1:0][PREG_W-1:0] e_prd;
  logic [DEPTH-1:0][63:0]       e_src1, e_src2, e_imm, e_pc;
  logic [DEPTH-1:0][ROB_W-1:0]  e_rob;
  logic [DEPTH-1:0][CTRL_W-1:0] e_ctrl;

  logic [IDX_W-1:0] free_idx, sel_idx;
  logic             sel_found, iss_fire, enq_fire, enq_younger;
  logic [CNT_W-1:0] cnt;

  // Lowest-index free slot (scan from the top so the lowest wins).
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (!e_vld[i]) free_idx = IDX_W'(i);
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) cnt = cnt + CNT_W'(e_vld[i]);
  end

  // Oldest ready entry; robidx values are unique so there are no ties.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (e_rdy[i] && (!sel_found ||
          older(e_flag[i], e_rob[i], e_flag[sel_idx], e_rob[sel_idx]))) begin
        sel_idx   = IDX_W'(i);
        sel_found = 1'b1;
      end
  end

  assign occupancy   = cnt;
  // Full check ignores a same-cycle issue: no full-bypass.
  assign enq_ready   = (cnt != CNT_W'(DEPTH));
  assign iss_fire    = sel_found & ~redirect_valid;
  assign enq_younger = redirect_valid &
                       older(redirect_robidx_flag, redirect_robidx, enq_robidx_flag, enq_robidx);
  assign enq_fire    = enq_valid & enq_ready & ~enq_younger;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    assign e_we[g]  = enq_fire & (free_idx == IDX_W'(g));
    assign e_clr[g] = (redirect_valid &
                       older(redirect_robidx_flag, redirect_robidx, e_flag[g], e_rob[g])) |
                      (iss_fire & (sel_idx == IDX_W'(g)));

    int_issue_queue_entry #(.PREG_W(PREG_W), .ROB_W(ROB_W), .CTRL_W(CTRL_W)) u_ent (
      .clock          (clock),
      .reset          (reset),
      .we_i           (e_we[g]),
      .clr_i          (e_clr[g]),
      .enq_prd_i      (enq_prd),
      .enq_prs1_i     (enq_prs1),
      .enq_prs2_i     (enq_prs2),
      .enq_src1_rdy_i (enq_src1_rdy),
      .enq_src2_rdy_i (enq_src2_rdy),
      .enq_src1_i     (enq_src1),
      .enq_src2_i     (enq_src2),
      .enq_imm_i      (enq_imm),
      .enq_pc_i       (enq_pc),
      .enq_flag_i     (enq_robidx_flag),
      .enq_rob_i      (enq_robidx),
      .enq_ctrl_i     (enq_ctrl),
      .wb_valid_i     (wb_valid),
      .wb_prd_i       (wb_prd),
      .wb_result_i    (wb_result),
      .vld_o          (e_vld[g]),
      .rdy_o          (e_rdy[g]),
      .prd_o          (e_prd[g]),
      .src1_o         (e_src1[g]),
      .src2_o         (e_src2[g]),
      .imm_o          (e_imm[g]),
      .pc_o           (e_pc[g]),
      .flag_o         (e_flag[g]),
      .rob_o          (e_rob[g]),
      .ctrl_o         (e_ctrl[g])
    );
  end

  // Issue bundle is forced to zero when nothing issues.
  assign iss_valid       = iss_fire;
  assign iss_prd         = iss_fire ? e_prd[sel_idx]  : '0;
  assign iss_src1        = iss_fire ? e_src1[sel_idx] : '0;
  assign iss_src2        = iss_fire ? e_src2[sel_idx] : '0;
  assign iss_imm         = iss_fire ? e_imm[sel_idx]  : '0;
  assign iss_pc          = iss_fire ? e_pc[sel_idx]   : '0;
  assign iss_robidx_flag = iss_fire & e_flag[sel_idx];
  assign iss_robidx      = iss_fire ? e_rob[sel_idx]  : '0;
  assign iss_ctrl        = iss_fire ? e_ctrl[sel_idx] : '0;
endmodule

// File: tb/tb_int_issue_queue.sv
module tb_int_issue_queue;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        enq_valid, enq_ready;
  logic [5:0]  enq_prd, enq_prs1, enq_prs2;
  logic        enq_src1_rdy, enq_src2_rdy;
  logic [63:0] enq_src1, enq_src2, enq_imm, enq_pc;
  logic        enq_robidx_flag;
  logic [5:0]  enq_robidx;
  logic [31:0] enq_ctrl;
  logic        wb_valid;
  logic [5:0]  wb_prd;
  logic [63:0] wb_result;
  logic        redirect_valid, redirect_robidx_flag;
  logic [5:0]  redirect_robidx;
  logic        iss_valid, iss_robidx_flag;
  logic [5:0]  iss_prd, iss_robidx;
  logic [63:0] iss_src1, iss_src2, iss_imm, iss_pc;
  logic [31:0] iss_ctrl;
  logic [3:0]  occupancy;

  always #5 clk = ~clk;

  int_issue_queue dut (
    .clock(clk), .reset(reset),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_prd(enq_prd),
    .enq_prs1(enq_prs1), .enq_prs2(enq_prs2),
    .enq_src1_rdy(enq_src1_rdy), .enq_src2_rdy(enq_src2_rdy),
    .enq_src1(enq_src1), .enq_src2(enq_src2), .enq_imm(enq_imm), .enq_pc(enq_pc),
    .enq_robidx_flag(enq_robidx_flag), .enq_robidx(enq_robidx), .enq_ctrl(enq_ctrl),
    .wb_valid(wb_valid), .wb_prd(wb_prd), .wb_result(wb_result),
    .redirect_valid(redirect_valid), .redirect_robidx_flag(redirect_robidx_flag),
    .redirect_robidx(redirect_robidx),
    .iss_valid(iss_valid), .iss_prd(iss_prd), .iss_src1(iss_src1), .iss_src2(iss_src2),
    .iss_imm(iss_imm), .iss_pc(iss_pc), .iss_robidx_flag(iss_robidx_flag),
    .iss_robidx(iss_robidx), .iss_ctrl(iss_ctrl), .occupancy(occupancy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: an unordered bag of uops ----------
  typedef struct {
    logic [5:0]  prd, prs1, prs2;
    bit          r1, r2;
    logic [63:0] s1, s2, imm, pc;
    bit          f;
    logic [5:0]  rob;
    logic [31:0] ctrl;
  } ent_t;

  ent_t mq[$];

  function automatic bit m_older(bit fa, logic [5:0] ia, bit fb, logic [5:0] ib);
    return (fa == fb) ? (ia < ib) : (ia > ib);
  endfunction

  function automatic bit m_ready(ent_t e);
`ifdef ISQ_WAKEUP_BYPASS_EN
    bit w1, w2;
    w1 = wb_valid && (e.prs1 == wb_prd);
    w2 = wb_valid && (e.prs2 == wb_prd);
    return (e.r1 || w1) && (e.r2 || w2);
`else
    return e.r1 && e.r2;
`endif
  endfunction

  function automatic int m_sel();
    int b = -1;
    foreach (mq[i])
      if (m_ready(mq[i]) && (b < 0 || m_older(mq[i].f, mq[i].rob, mq[b].f, mq[b].rob)))
        b = i;
    return b;
  endfunction

  // compare process
  int          c_s;
  bit          c_v;
  ent_t        c_e;
  logic [63:0] c_s1, c_s2;
  always @(negedge clk) if (chk_en) begin
    c_s = m_sel();
    c_v = (c_s >= 0) && !redirect_valid;
    c_e = '{default: '0};
    c_s1 = '0;
    c_s2 = '0;
    if (c_v) begin
      c_e  = mq[c_s];
      c_s1 = c_e.r1 ? c_e.s1 : wb_result;
      c_s2 = c_e.r2 ? c_e.s2 : wb_result;
    end
    chk("m_iss_valid", 64'(iss_valid), 64'(c_v));
    chk("m_iss_prd",   64'(iss_prd), 64'(c_e.prd));
    chk("m_iss_src1",  iss_src1, c_s1);
    chk("m_iss_src2",  iss_src2, c_s2);
    chk("m_iss_imm",   iss_imm, c_e.imm);
    chk("m_iss_pc",    iss_pc, c_e.pc);
    chk("m_iss_age",   64'({iss_robidx_flag, iss_robidx}), 64'({c_e.f, c_e.rob}));
    chk("m_iss_ctrl",  64'(iss_ctrl), 64'(c_e.ctrl));
    chk("m_occupancy", 64'(occupancy), 64'(mq.size()));
    chk("m_enq_ready", 64'(enq_ready), 64'(mq.size() != DEPTH));
  end

  // model update at each active edge
  ent_t nq[$];
  ent_t ne;
  int   u_s, u_osz;
  bit   u_iss;
  always @(posedge clk) begin
    if (reset) mq.delete();
    else begin
      u_s   = m_sel();
      u_iss = (u_s >= 0) && !redirect_valid;
      u_osz = mq.size();
      nq.delete();
      foreach (mq[i]) begin
        ne = mq[i];
        if (redirect_valid && m_older(redirect_robidx_flag, redirect_robidx, ne.f, ne.rob)) continue;
        if (u_iss && i == u_s) continue;
        if (wb_valid && !ne.r1 && ne.prs1 == wb_prd) begin ne.r1 = 1; ne.s1 = wb_result; end
        if (wb_valid && !ne.r2 && ne.prs2 == wb_prd) begin ne.r2 = 1; ne.s2 = wb_result; end
        nq.push_back(ne);
      end
      if (enq_valid && u_osz < DEPTH &&
          !(redirect_valid && m_older(redirect_robidx_flag, redirect_robidx,
                                      enq_robidx_flag, enq_robidx))) begin
        ne.prd = enq_prd; ne.prs1 = enq_prs1; ne.prs2 = enq_prs2;
        ne.r1  = enq_src1_rdy || (wb_valid && enq_prs1 == wb_prd);
        ne.r2  = enq_src2_rdy || (wb_valid && enq_prs2 == wb_prd);
        ne.s1  = enq_src1_rdy ? enq_src1 : wb_result;
        ne.s2  = enq_src2_rdy ? enq_src2 : wb_result;
        ne.imm = enq_imm; ne.pc = enq_pc; ne.f = enq_robidx_flag;
        ne.rob = enq_robidx; ne.ctrl = enq_ctrl;
        nq.push_back(ne);
      end
      mq = nq;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    enq_valid = 0; enq_prd = 0; enq_prs1 = 0; enq_prs2 = 0;
    enq_src1_rdy = 0; enq_src2_rdy = 0; enq_src1 = 0; enq_src2 = 0;
    enq_imm = 0; enq_pc = 0; enq_robidx_flag = 0; enq_robidx = 0; enq_ctrl = 0;
    wb_valid = 0; wb_prd = 0; wb_result = 0;
    redirect_valid = 0; redirect_robidx_flag = 0; redirect_robidx = 0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic enq(input logic [5:0] prd, input logic [5:0] p1, input bit r1,
                     input logic [63:0] s1, input logic [5:0] p2, input bit r2,
                     input logic [63:0] s2, input bit f, input logic [5:0] rob);
    enq_valid = 1; enq_prd = prd; enq_prs1 = p1; enq_prs2 = p2;
    enq_src1_rdy = r1; enq_src2_rdy = r2; enq_src1 = s1; enq_src2 = s2;
    enq_robidx_flag = f; enq_robidx = rob;
    enq_imm  = 64'h1000 + 64'(rob);
    enq_pc   = 64'h8000_0000 + 64'(rob) * 4;
    enq_ctrl = 32'hA5A5_0000 | 32'(rob);
  endtask

  task automatic wbset(input logic [5:0] prd, input logic [63:0] res);
    wb_valid = 1; wb_prd = prd; wb_result = res;
  endtask

  bit   t3_f[8]  = '{1, 0, 1, 0, 1, 1, 1, 1};
  int   t3_r[8]  = '{1, 7, 3, 6, 0, 5, 2, 4};
  int   t3_ex[8] = '{6, 7, 64, 65, 66, 67, 68, 69};

  initial begin
    idle();
    reset = 1;
    @(posedge clk); @(posedge clk); #1;
    reset = 0;
    chk_en = 1;
    @(negedge clk);
    chk("rst_occ", 64'(occupancy), 0);
    chk("rst_enq_ready", 64'(enq_ready), 1);
    chk("rst_iss_valid", 64'(iss_valid), 0);
    chk("rst_iss_src1", iss_src1, 0);
    nxt();

    // T1: single ready uop
    enq(5, 0, 1, 3, 0, 1, 4, 0, 2);
    @(negedge clk); chk("t1_no_iss_same_cycle", 64'(iss_valid), 0); nxt();
    @(negedge clk);
    chk("t1_iss_valid", 64'(iss_valid), 1);
    chk("t1_iss_prd", 64'(iss_prd), 5);
    chk("t1_iss_src1", iss_src1, 3);
    chk("t1_iss_src2", iss_src2, 4);
    nxt();
    @(negedge clk);
    chk("t1_after_valid", 64'(iss_valid), 0);
    chk("t1_after_occ", 64'(occupancy), 0);
    nxt();

    // T2: wakeup two cycles after enqueue
    enq(8, 7, 0, 0, 1, 1, 1, 0, 3);
    @(negedge clk); nxt();
    @(negedge clk); chk("t2_waiting", 64'(iss_valid), 0); nxt();
    wbset(7, 64'h55);
    @(negedge clk);
`ifdef ISQ_WAKEUP_BYPASS_EN
    chk("t2_wb_cycle_valid", 64'(iss_valid), 1);
    chk("t2_wb_cycle_src1", iss_src1, 64'h55);
`else
    chk("t2_wb_cycle_valid", 64'(iss_valid), 0);
`endif
    nxt();
    @(negedge clk);
`ifdef ISQ_WAKEUP_BYPASS_EN
    chk("t2_after_valid", 64'(iss_valid), 0);
`else
    chk("t2_after_valid", 64'(iss_valid), 1);
    chk("t2_after_src1", iss_src1, 64'h55);
`endif
    nxt();
    @(negedge clk); chk("t2_empty", 64'(occupancy), 0); nxt();

    // T3: fill, reject 9th, wake all, age-ordered drain
    for (int k = 0; k < 8; k++) begin
      enq(6'(20 + k), 21, 0, 0, 0, 1, 64'(k), t3_f[k], 6'(t3_r[k]));
      @(negedge clk); nxt();
    end
    enq(30, 0, 1, 1, 0, 1, 2, 0, 9);
    @(negedge clk);
    chk("t3_full_ready", 64'(enq_ready), 0);
    chk("t3_full_occ", 64'(occupancy), 8);
    nxt();
    wbset(21, 64'h77);
    @(negedge clk);
    chk("t3_9th_rejected", 64'(occupancy), 8);
`ifndef ISQ_WAKEUP_BYPASS_EN
    chk("t3_wb_cycle_valid", 64'(iss_valid), 0);
    nxt();
`endif
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      chk("t3_order_valid", 64'(iss_valid), 1);
      chk("t3_order_age", 64'({iss_robidx_flag, iss_robidx}), 64'(t3_ex[k]));
      chk("t3_order_src1", iss_src1, 64'h77);
      nxt();
    end
    @(negedge clk);
    chk("t3_drained", 64'(occupancy), 0);
    nxt();

    // T4: redirect squashes younger, suppresses issue, wakeup still lands
    for (int k = 0; k < 3; k++) begin
      enq(6'(40 + k), 30, 0, 0, 0, 1, 1, 0, 6'(3 + k));
      @(negedge clk); nxt();
    end
    redirect_valid = 1; redirect_robidx_flag = 0; redirect_robidx = 3;
    wbset(30, 64'h99);
    enq(43, 0, 1, 1, 0, 1, 1, 0, 6);
    @(negedge clk);
    chk("t4_redirect_no_iss", 64'(iss_valid), 0);
    chk("t4_redirect_occ", 64'(occupancy), 3);
    nxt();
    @(negedge clk);
    chk("t4_squash_occ", 64'(occupancy), 1);
    chk("t4_iss_valid", 64'(iss_valid), 1);
    chk("t4_iss_rob", 64'(iss_robidx), 3);
    chk("t4_iss_src1", iss_src1, 64'h99);
    nxt();
    @(negedge clk); chk("t4_empty", 64'(occupancy), 0); nxt();

    // T5: wakeup coincides with enqueue
    enq(50, 0, 1, 64'h11, 9, 0, 0, 0, 7);
    wbset(9, 64'hAB);
    @(negedge clk); chk("t5_same_cycle", 64'(iss_valid), 0); nxt();
    @(negedge clk);
    chk("t5_iss_valid", 64'(iss_valid), 1);
    chk("t5_iss_prd", 64'(iss_prd), 50);
    chk("t5_iss_src2", iss_src2, 64'hAB);
    nxt();

    // T6: enqueue + issue + wakeup in one cycle
    enq(60, 51, 0, 0, 0, 1, 1, 0, 10);
    @(negedge clk); nxt();
    enq(61, 0, 1, 2, 0, 1, 3, 0, 11);
    @(negedge clk); nxt();
    enq(62, 0, 1, 4, 0, 1, 5, 0, 12);
    wbset(51, 64'h5A);
    @(negedge clk);
    chk("t6_c3_occ", 64'(occupancy), 2);
`ifndef ISQ_WAKEUP_BYPASS_EN
    chk("t6_c3_rob", 64'(iss_robidx), 11);
`endif
    nxt();
    @(negedge clk);
    chk("t6_c4_occ", 64'(occupancy), 2);
`ifndef ISQ_WAKEUP_BYPASS_EN
    chk("t6_c4_rob", 64'(iss_robidx), 10);
    chk("t6_c4_src1", iss_src1, 64'h5A);
`endif
    nxt();
    @(negedge clk); chk("t6_c5_occ", 64'(occupancy), 1); nxt();
    @(negedge clk); chk("t6_c6_occ", 64'(occupancy), 0); nxt();

    // T7: reset with live entries
    for (int k = 0; k < 5; k++) begin
      enq(6'(20 + k), 55, 0, 0, 0, 1, 1, 0, 6'(20 + k));
      @(negedge clk); nxt();
    end
    reset = 1;
    enq(30, 0, 1, 1, 0, 1, 1, 0, 25);
    wbset(55, 64'h1);
    @(negedge clk); chk("t7_pre_rst_occ", 64'(occupancy), 5);
    nxt();
    reset = 0;
    @(negedge clk);
    chk("t7_occ", 64'(occupancy), 0);
    chk("t7_iss_valid", 64'(iss_valid), 0);
    chk("t7_enq_ready", 64'(enq_ready), 1);
    nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
